// File: rtl/code_sender_if.sv
// code_sender_if -- handshake and button bus for code_sender.
//   start, abort : send request / cancel (master -> slave)
//   code, sw     : four 2-bit symbols (symbol 0 in [1:0]) and mirror select
//   btnR/L/U/D   : generated button levels (slave -> master)
//   busy, done   : send in progress / one-cycle completion pulse
interface code_sender_if;
  logic       start;
  logic       abort;
  logic [7:0] code;
  logic       sw;
  logic       btnR, btnL, btnU, btnD;
  logic       busy;
  logic       done;

  modport master (output start, abort, code, sw,
                  input  btnR, btnL, btnU, btnD, busy, done);
  modport slave  (input  start, abort, code, sw,
                  output btnR, btnL, btnU, btnD, busy, done);
endinterface

// File: rtl/code_sender.sv
// code_sender -- plays a 4-symbol button code as timed presses.
//   Each symbol holds one button high for PRESS_CYCLES, then all buttons
//   are low for GAP_CYCLES; done pulses once after the fourth gap.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : code_sender_if.slave (start, abort, code, sw in;
//           btnR/L/U/D, busy, done out, all registered)
// Option: define CODE_SENDER_MIRROR_EN to honour sw (R<->L, U<->D);
//   without it sw is accepted but ignored.
module code_sender #(
  parameter int unsigned PRESS_CYCLES = 3,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic          clk,
  input  logic          reset,
  code_sender_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PRESS, GAP, DONE} state_t;

  localparam logic [31:0] P_LAST = 32'(PRESS_CYCLES - 1);
  localparam logic [31:0] G_LAST = 32'(GAP_CYCLES - 1);

  state_t      state;
  logic [31:0] cnt;
  logic [1:0]  idx;
  logic [7:0]  code_q;
  logic [3:0]  btn;      // {D,U,L,R}
  logic        busy_q;
  logic        done_q;
  logic [1:0]  idx_nxt;

`ifdef CODE_SENDER_MIRROR_EN
  logic sw_q;
  wire  mir_start = bus.sw;
  wire  mir_run   = sw_q;
`else
  wire  mir_start = 1'b0;
  wire  mir_run   = 1'b0;
`endif

  assign idx_nxt = idx + 2'd1;

  // Encoding 0=R,1=L,2=U,3=D: flipping bit 0 swaps R<->L and U<->D.
  function automatic logic [3:0] btn_of(input logic [1:0] sym, input logic mir);
    logic [1:0] s;
    s = sym ^ {1'b0, mir};
    return 4'b0001 << s;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      code_q <= '0;
      btn    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef CODE_SENDER_MIRROR_EN
      sw_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          // abort wins over start, so both together stay idle
          if (bus.start && !bus.abort) begin
            code_q <= bus.code;
`ifdef CODE_SENDER_MIRROR_EN
            sw_q   <= bus.sw;
`endif
            idx    <= '0;
            cnt    <= '0;
            btn    <= btn_of(bus.code[1:0], mir_start);
            busy_q <= 1'b1;
            state  <= PRESS;
          end
        end
        PRESS, GAP: begin
          if (bus.abort) begin
            btn    <= '0;
            busy_q <= 1'b0;
            cnt    <= '0;
            idx    <= '0;
            state  <= IDLE;
          end else if (state == PRESS) begin
            if (cnt == P_LAST) begin
              btn   <= '0;
              cnt   <= '0;
              state <= GAP;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end else begin
            if (cnt == G_LAST) begin
              cnt <= '0;
              if (idx == 2'd3) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
                state  <= DONE;
              end else begin
                idx   <= idx_nxt;
                btn   <= btn_of(code_q[{idx_nxt, 1'b0} +: 2], mir_run);
                state <= PRESS;
              end
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
        end
        DONE: begin
          // start is not looked at here; a held start launches from IDLE
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.btnR = btn[0];
  assign bus.btnL = btn[1];
  assign bus.btnU = btn[2];
  assign bus.btnD = btn[3];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: doc/code_sender.md
CODE_SENDER -- requirements
Module: code_sender

Interface
REQ-001 SHALL have parameter PRESS_CYCLES, default 3: clock cycles each button is held high; legal range 1 to 2^32-1.
REQ-002 SHALL have parameter GAP_CYCLES, default 2: all-low clock cycles after each press; legal range 1 to 2^32-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to send the code; acted on only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: cancels a send in progress.
REQ-007 SHALL have port code, input, 8 bits: four 2-bit symbols; symbol k is code[2k+1:2k]; symbol 0 is sent first; encoding 0=R, 1=L, 2=U, 3=D.
REQ-008 SHALL have port sw, input, 1 bit: mirror select (see Configuration).
REQ-009 SHALL have ports btnR, btnL, btnU, btnD, output, 1 bit each: generated button levels.
REQ-010 SHALL have port busy, output, 1 bit: a send is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when all four symbols have been sent.

Function
REQ-012 SHALL implement an FSM with states IDLE, PRESS, GAP and DONE.
REQ-013 SHALL register every output; no output is driven combinationally from inputs.
REQ-014 In IDLE, when start=1, SHALL latch code and sw, clear the symbol index and duration counter, and go to PRESS.
REQ-015 If start is sampled high at cycle t, the button for symbol k SHALL be high during cycles t+1+k*(P+G) through t+k*(P+G)+P, where P=PRESS_CYCLES and G=GAP_CYCLES.
REQ-016 SHALL drive exactly one button high in PRESS and all buttons low in every other state (one-hot-or-zero).
REQ-017 After P cycles in PRESS, SHALL go to GAP; after G cycles in GAP, SHALL go to PRESS with the next symbol, or to DONE after symbol 3.
REQ-018 SHALL use a 32-bit duration counter that restarts at 0 on every state entry; a 2-bit symbol index SHALL increment on each GAP exit.
REQ-019 SHALL assert busy from cycle t+1 through t+4(P+G).
REQ-020 SHALL pulse done for one cycle at t+1+4(P+G), then return to IDLE.
REQ-021 SHALL ignore start while busy=1; changes to code or sw during a send SHALL have no effect.
REQ-022 SHALL give abort priority over start and over normal progress.
REQ-023 abort=1 in PRESS or GAP SHALL drive all buttons and busy low on the next cycle and return to IDLE with no done pulse; abort in IDLE or DONE has no effect.
REQ-024 start and abort high together in IDLE SHALL leave the block in IDLE.
REQ-025 start held high continuously SHALL start a new send in the IDLE cycle that follows DONE.

Reset
REQ-026 reset=1 at a rising edge SHALL force state=IDLE, btnR=btnL=btnU=btnD=0, busy=0, done=0, counters=0 and latched code/sw=0.
REQ-027 reset SHALL have priority over start and abort.
REQ-028 reset mid-send SHALL end the send without a done pulse.

Configuration
REQ-029 SHALL provide macro CODE_SENDER_MIRROR_EN.
REQ-030 With CODE_SENDER_MIRROR_EN defined and latched sw=1, SHALL send each symbol mirrored: R<->L and U<->D.
REQ-031 Without CODE_SENDER_MIRROR_EN, the sw port SHALL remain present but be ignored; symbols are sent unmirrored.

Verification
REQ-032 P=3, G=2, code=8'h16, sw=0, start pulse at t -> U high t+1..t+3, L high t+6..t+8, L high t+11..t+13, R high t+16..t+18, busy t+1..t+20, done at t+21.
REQ-033 MIRROR_EN defined, code=8'h16, sw=1 -> sequence D, R, R, L with the same timing as REQ-032; MIRROR_EN undefined -> U, L, L, R.
REQ-034 P=1, G=1, code=8'hE4 -> R, L, U, D each high one cycle with one low cycle between presses; done at t+9; at most one button high in any cycle.
REQ-035 abort at t+7 during the second press -> all buttons and busy 0 at t+8; no done; a new start at t+9 restarts from symbol 0.
REQ-036 start pulse during busy, and code changed to 8'hFF mid-send -> original sequence unchanged; exactly one done.
REQ-037 reset at t+12 -> all outputs 0 at t+13; start at t+14 -> full sequence beginning at t+15.
